// File: rtl/bt_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// bt_cmd_ctrl
//
// Command-frame controller behind the UART receive path. Assembles fixed
// 4-byte frames {HDR_BYTE, OP, ARG, CHK}, where CHK = (OP + ARG) mod 256.
// A good frame with OP 01 or 02 writes ARG into control register A or B.
// Bad checksums, unknown opcodes and (optionally) stalled frames are
// rejected, reported and counted.
//
// Optional feature macro: BT_CMD_TIMEOUT_EN
//   defined   : inter-byte timeout counter present; err_code 3 on expiry
//   undefined : no counter; partial frames wait indefinitely
//
// Parameters
//   TIMEOUT_CYC  inter-byte timeout in clock cycles (2 .. 2^20-1)
//   HDR_BYTE     frame header value
//
// Ports
//   clk_10Hz   in   system clock, rising-edge
//   reset      in   asynchronous active-low reset
//   rx_valid   in   one-cycle byte strobe
//   rx_byte    in   received byte [7:0]
//   cmd_valid  out  one-cycle pulse, frame accepted and applied
//   cmd_op     out  opcode of last accepted frame [7:0]
//   cmd_arg    out  argument of last accepted frame [7:0]
//   ctrl_a     out  control register A (op 01) [7:0]
//   ctrl_b     out  control register B (op 02) [7:0]
//   err_pulse  out  one-cycle pulse, frame rejected
//   err_code   out  last reject reason: 1 checksum, 2 opcode, 3 timeout
//   err_cnt    out  saturating reject counter [7:0]
//   busy       out  high while a frame is being assembled
// -----------------------------------------------------------------------------
module bt_cmd_ctrl #(
  parameter int          TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  HDR_BYTE    = 8'hAA
) (
  input  logic       clk_10Hz,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       cmd_valid,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_arg,
  output logic [7:0] ctrl_a,
  output logic [7:0] ctrl_b,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GET_OP  = 2'd1,
    GET_ARG = 2'd2,
    GET_CHK = 2'd3
  } state_t;

  function automatic logic [7:0] chk_sum(input logic [7:0] op, input logic [7:0] arg);
    return op + arg;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] cmd_op_q, cmd_op_d;
  logic [7:0] cmd_arg_q, cmd_arg_d;
  logic [7:0] ctrl_a_q, ctrl_a_d;
  logic [7:0] ctrl_b_q, ctrl_b_d;
  logic       err_pulse_q, err_pulse_d;
  logic [1:0] err_code_q, err_code_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] op_q, op_d;
  logic [7:0] arg_q, arg_d;
  logic       tmo_hit;

`ifdef BT_CMD_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

  logic [19:0] tmo_cnt_q, tmo_cnt_d;

  // A byte arriving in the expiry cycle wins, so expiry is masked by rx_valid.
  assign tmo_hit = (state_q != HUNT) && !rx_valid && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 20'd1;
    if ((state_q == HUNT) || rx_valid || tmo_hit) begin
      tmo_cnt_d = 20'd0;
    end
  end

  always_ff @(posedge clk_10Hz or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= 20'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    logic       rej;
    logic [1:0] rej_code;
    state_d     = state_q;
    cmd_valid_d = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_arg_d   = cmd_arg_q;
    ctrl_a_d    = ctrl_a_q;
    ctrl_b_d    = ctrl_b_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;
    op_d        = op_q;
    arg_d       = arg_q;
    rej         = 1'b0;
    rej_code    = 2'd0;

    case (state_q)
      HUNT: begin
        if (rx_valid && (rx_byte == HDR_BYTE)) begin
          state_d = GET_OP;
        end
      end
      GET_OP: begin
        if (rx_valid) begin
          op_d    = rx_byte;
          state_d = GET_ARG;
        end
      end
      GET_ARG: begin
        if (rx_valid) begin
          arg_d   = rx_byte;
          state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (rx_valid) begin
          state_d = HUNT;
          if (rx_byte != chk_sum(op_q, arg_q)) begin
            rej      = 1'b1;
            rej_code = 2'd1;
          end else if (op_q == 8'h01) begin
            ctrl_a_d    = arg_q;
            cmd_op_d    = op_q;
            cmd_arg_d   = arg_q;
            cmd_valid_d = 1'b1;
          end else if (op_q == 8'h02) begin
            ctrl_b_d    = arg_q;
            cmd_op_d    = op_q;
            cmd_arg_d   = arg_q;
            cmd_valid_d = 1'b1;
          end else begin
            rej      = 1'b1;
            rej_code = 2'd2;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (tmo_hit) begin
      state_d  = HUNT;
      rej      = 1'b1;
      rej_code = 2'd3;
    end

    if (rej) begin
      err_pulse_d = 1'b1;
      err_code_d  = rej_code;
      err_cnt_d   = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk_10Hz or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 8'd0;
      cmd_arg_q   <= 8'd0;
      ctrl_a_q    <= 8'd0;
      ctrl_b_q    <= 8'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_arg_q   <= cmd_arg_d;
      ctrl_a_q    <= ctrl_a_d;
      ctrl_b_q    <= ctrl_b_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Frame holding registers are only read after being written in the same
  // frame, so they carry no reset.
  always_ff @(posedge clk_10Hz) begin
    op_q  <= op_d;
    arg_q <= arg_d;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_arg   = cmd_arg_q;
  assign ctrl_a    = ctrl_a_q;
  assign ctrl_b    = ctrl_b_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != HUNT);

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bt_cmd_ctrl
//
// Self-checking bench for bt_cmd_ctrl. A frame-level reference model
// (byte list + cycle stamps) predicts all outputs; a negedge process compares
// every output every cycle. Directed frames pin the model with literal values,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_bt_cmd_ctrl;

  localparam int         TMO = 100;
  localparam logic [7:0] HDR = 8'hAA;
`ifdef BT_CMD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk_10Hz = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte  = 8'h00;
  logic       cmd_valid;
  logic [7:0] cmd_op, cmd_arg, ctrl_a, ctrl_b;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic       busy;

  bt_cmd_ctrl #(.TIMEOUT_CYC(TMO), .HDR_BYTE(HDR)) dut (
    .clk_10Hz (clk_10Hz),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .ctrl_a   (ctrl_a),
    .ctrl_b   (ctrl_b),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk_10Hz = ~clk_10Hz;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic       e_cmd_valid = 0, e_err_pulse = 0, e_busy = 0;
  logic [7:0] e_cmd_op = 0, e_cmd_arg = 0, e_ctrl_a = 0, e_ctrl_b = 0, e_err_cnt = 0;
  logic [1:0] e_err_code = 0;
  logic [7:0] frame [4];
  int         m_len  = 0;   // bytes of the current frame collected, 0 = hunting
  longint     cyc    = 0;
  longint     last_b = 0;   // cycle of the last byte consumed into a frame

  task automatic m_reject(input logic [1:0] c);
    e_err_pulse = 1'b1;
    e_err_code  = c;
    if (e_err_cnt != 8'd255) e_err_cnt = e_err_cnt + 8'd1;
  endtask

  task automatic m_reset();
    e_cmd_valid = 0; e_err_pulse = 0; e_busy = 0;
    e_cmd_op = 0; e_cmd_arg = 0; e_ctrl_a = 0; e_ctrl_b = 0;
    e_err_cnt = 0; e_err_code = 0; m_len = 0;
  endtask

  // Called at each active edge with the inputs present in the ending cycle.
  task automatic m_edge(input logic v, input logic [7:0] b);
    logic [7:0] s;
    e_cmd_valid = 0;
    e_err_pulse = 0;
    cyc++;
    if (m_len == 0) begin
      if (v && b == HDR) begin
        frame[0] = b; m_len = 1; last_b = cyc;
      end
    end else if (v) begin
      frame[m_len] = b; m_len++; last_b = cyc;
      if (m_len == 4) begin
        m_len = 0;
        s = 8'((int'(frame[1]) + int'(frame[2])) % 256);
        if (frame[3] != s) m_reject(2'd1);
        else if (frame[1] == 8'h01) begin
          e_ctrl_a = frame[2]; e_cmd_op = frame[1]; e_cmd_arg = frame[2]; e_cmd_valid = 1;
        end else if (frame[1] == 8'h02) begin
          e_ctrl_b = frame[2]; e_cmd_op = frame[1]; e_cmd_arg = frame[2]; e_cmd_valid = 1;
        end else m_reject(2'd2);
      end
    end else if (TMO_EN && (cyc - last_b == longint'(TMO))) begin
      m_reject(2'd3);
      m_len = 0;
    end
    e_busy = (m_len != 0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_10Hz) begin
    check("cmd_valid", 32'(cmd_valid), 32'(e_cmd_valid));
    check("cmd_op",    32'(cmd_op),    32'(e_cmd_op));
    check("cmd_arg",   32'(cmd_arg),   32'(e_cmd_arg));
    check("ctrl_a",    32'(ctrl_a),    32'(e_ctrl_a));
    check("ctrl_b",    32'(ctrl_b),    32'(e_ctrl_b));
    check("err_pulse", 32'(err_pulse), 32'(e_err_pulse));
    check("err_code",  32'(err_code),  32'(e_err_code));
    check("err_cnt",   32'(err_cnt),   32'(e_err_cnt));
    check("busy",      32'(busy),      32'(e_busy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_byte  = b;
    @(posedge clk_10Hz);
    m_edge(v, b);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send4(input logic [7:0] b0, b1, b2, b3);
    step(1'b1, b0); step(1'b1, b1); step(1'b1, b2); step(1'b1, b3);
  endtask

  task automatic rnd_byte(input logic [7:0] b);
    int g;
    if ($urandom_range(0, 19) == 0) g = $urandom_range(TMO - 3, TMO + 1);
    else if ($urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
    else g = 0;
    idle(g);
    step(1'b1, b);
  endtask

  initial begin
    logic [7:0] op, arg, ck;
    int k;
    #2 reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clk_10Hz);
    #1;
    check("rst_ctrl_a", 32'(ctrl_a), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk_10Hz);
    #1 reset = 1'b1;

    // Basic accept, op 01
    send4(8'hAA, 8'h01, 8'h5A, 8'h5B);
    check("f1_cmd_valid", 32'(cmd_valid), 32'h1);
    check("f1_ctrl_a", 32'(ctrl_a), 32'h5A);
    check("f1_cmd_op", 32'(cmd_op), 32'h01);
    check("f1_cmd_arg", 32'(cmd_arg), 32'h5A);
    check("f1_ctrl_b", 32'(ctrl_b), 32'h00);
    check("f1_err_cnt", 32'(err_cnt), 32'h0);
    check("f1_busy", 32'(busy), 32'h0);

    // Back-to-back, wrapping checksum, header arrives while cmd_valid high
    send4(8'hAA, 8'h02, 8'hFF, 8'h01);
    check("f2_ctrl_b", 32'(ctrl_b), 32'hFF);
    check("f2_cmd_valid", 32'(cmd_valid), 32'h1);

    // Bad checksum, then unknown opcode
    send4(8'hAA, 8'h01, 8'h10, 8'h12);
    check("f3_err_pulse", 32'(err_pulse), 32'h1);
    check("f3_err_code", 32'(err_code), 32'h1);
    check("f3_err_cnt", 32'(err_cnt), 32'h1);
    check("f3_ctrl_a", 32'(ctrl_a), 32'h5A);
    send4(8'hAA, 8'h03, 8'h00, 8'h03);
    check("f4_err_code", 32'(err_code), 32'h2);
    check("f4_err_cnt", 32'(err_cnt), 32'h2);
    idle(2);

`ifdef BT_CMD_TIMEOUT_EN
    // Stall after OP: expiry TMO cycles after the OP strobe
    step(1'b1, 8'hAA); step(1'b1, 8'h01);
    idle(TMO - 1);
    check("to_busy_before", 32'(busy), 32'h1);
    idle(1);
    check("to_err_pulse", 32'(err_pulse), 32'h1);
    check("to_err_code", 32'(err_code), 32'h3);
    check("to_busy_after", 32'(busy), 32'h0);
    idle(3);
    // ARG arriving in the expiry cycle wins
    step(1'b1, 8'hAA); step(1'b1, 8'h01);
    idle(TMO - 1);
    step(1'b1, 8'h22);
    check("to_edge_no_err", 32'(err_pulse), 32'h0);
    check("to_edge_busy", 32'(busy), 32'h1);
    step(1'b1, 8'h23);
    check("to_edge_accept", 32'(cmd_valid), 32'h1);
    check("to_edge_ctrl_a", 32'(ctrl_a), 32'h22);
    idle(2);
`endif

    // Junk, then reset in the middle of a frame, then resend
    step(1'b1, 8'h00); step(1'b1, 8'h13); step(1'b1, 8'hAA); step(1'b1, 8'h02);
    rx_valid = 1'b1; rx_byte = 8'h33;
    #3 reset = 1'b0;
    m_reset();
    #1;
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    check("mid_rst_ctrl_a", 32'(ctrl_a), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk_10Hz);
    #1 rx_valid = 1'b0;
    @(negedge clk_10Hz);
    #1 reset = 1'b1;
    step(1'b1, 8'h00); step(1'b1, 8'h13);
    send4(8'hAA, 8'h02, 8'h33, 8'h35);
    check("resend_ctrl_b", 32'(ctrl_b), 32'h33);
    check("resend_err_cnt", 32'(err_cnt), 32'h0);

    // Saturation of the reject counter
    for (int i = 0; i < 300; i++) send4(8'hAA, 8'h01, 8'h10, 8'h12);
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      op  = 8'($urandom_range(1, 2));
      arg = 8'($urandom);
      ck  = op + arg;
      case (k)
        0, 1, 2, 3: ;
        4: ck = ck + 8'($urandom_range(1, 255));
        5: begin
          op = 8'($urandom);
          if (op == 8'h01 || op == 8'h02) op = 8'h03;
          ck = op + arg;
        end
        default: ;
      endcase
      if (k <= 5) begin
        rnd_byte(HDR); rnd_byte(op); rnd_byte(arg); rnd_byte(ck);
      end else if (k <= 7) begin
        rnd_byte(($urandom_range(0, 3) == 0) ? HDR : 8'($urandom));
      end else if (k == 8) begin
        idle($urandom_range(1, 5));
      end else begin
        idle($urandom_range(TMO - 10, TMO + 10));
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bt_cmd_ctrl.md
# bt_cmd_ctrl

Command-frame controller behind the UART receive path of the Bluetooth control design. Consumes decoded 8-bit bytes with a one-cycle valid strobe, assembles fixed 4-byte command frames, and checks header, checksum and opcode. It then updates two 8-bit control registers that drive downstream actuators and LEDs. Malformed or stalled frames are discarded, reported, and counted.

## Interface
Parameters:
- TIMEOUT_CYC, 1000000, inter-byte timeout in clk_10Hz cycles (100 ms at 10 MHz); must be ≥2 and <2^20.
- HDR_BYTE, 8'hAA, frame header value.

Ports:
- clk_10Hz  in  1  10 MHz system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid in that cycle. Back-to-back strobes in consecutive cycles are legal.
- rx_byte  in  8  received data byte.
- cmd_valid  out  1  one-cycle pulse; a frame was accepted and applied.
- cmd_op  out  8  opcode of the last accepted frame. Holds its value until the next accept.
- cmd_arg  out  8  argument of the last accepted frame. Holds its value until the next accept.
- ctrl_a  out  8  control register A; written by op 8'h01.
- ctrl_b  out  8  control register B; written by op 8'h02.
- err_pulse  out  1  one-cycle pulse; a frame was rejected.
- err_code  out  2  reason for the last rejection: 1 = checksum, 2 = unknown opcode, 3 = timeout. Holds its value until the next error.
- err_cnt  out  8  count of rejected frames; saturates at 255.
- busy  out  1  high whenever the state is not HUNT.

## Operation
- Frame format: HDR_BYTE, OP, ARG, CHK, where CHK = (OP + ARG) mod 256. The sum is 8-bit and the carry is discarded.
- FSM states: HUNT, GET_OP, GET_ARG, GET_CHK.
- HUNT:
  - rx_valid with rx_byte == HDR_BYTE → GET_OP.
  - Any other byte is ignored silently: no error, no count.
- GET_OP: rx_valid → latch OP, go to GET_ARG.
- GET_ARG: rx_valid → latch ARG, go to GET_CHK.
- GET_CHK: rx_valid → evaluate the frame and return to HUNT.
  - Checksum mismatch → error code 1.
  - Checksum good but OP not in {01, 02} → error code 2.
  - Otherwise accept:
    - Write ARG to ctrl_a (OP 01) or ctrl_b (OP 02).
    - Update cmd_op and cmd_arg.
    - Pulse cmd_valid.
- A HDR_BYTE value received in GET_OP, GET_ARG or GET_CHK is treated as data. There is no resynchronisation mid-frame.
- Timeout counter (macro-dependent, see Configuration):
  - Cleared on every accepted rx_valid.
  - Held at 0 in HUNT.
  - Otherwise increments by 1 per cycle.
  - Reaching TIMEOUT_CYC−1 in a non-HUNT state → error code 3, return to HUNT, discard the partial frame.
- Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins. It is processed normally and the counter clears.
- Every rejection:
  - Pulses err_pulse.
  - Updates err_code.
  - Increments err_cnt unless it is already 255.
  - Leaves ctrl_a, ctrl_b, cmd_op and cmd_arg unchanged.

## Timing
- Reset (asynchronous assert, any cycle including mid-frame) forces:
  - State to HUNT and the timeout counter to 0.
  - cmd_valid, err_pulse and busy to 0.
  - cmd_op, cmd_arg, ctrl_a, ctrl_b, err_code and err_cnt to 0.
- Reset deassertion is synchronised externally. The first byte is accepted on the first rising edge with reset high.
- Latency: cmd_valid, err_pulse and the ctrl_a/ctrl_b/cmd_* updates are registered. They appear one cycle after the CHK byte's rx_valid cycle.
- Timeout error pulse appears one cycle after the expiry cycle.
- busy rises one cycle after the header strobe. It falls in the same cycle that cmd_valid or err_pulse asserts.
- Minimum frame time is 4 cycles; a new header may arrive in the cycle cmd_valid is high.

## Configuration
- BT_CMD_TIMEOUT_EN defined: the timeout counter and error code 3 are implemented as described.
- Undefined:
  - No counter is synthesised.
  - A partial frame waits indefinitely for its remaining bytes.
  - err_code never takes value 3.
  - TIMEOUT_CYC is ignored.

## Test plan
- Frame AA 01 5A 5B → cmd_valid pulse one cycle after the 5B strobe. ctrl_a = 5A, cmd_op = 01, cmd_arg = 5A, ctrl_b = 00, err_cnt = 0.
- Frame AA 02 FF 01 (sum wraps to 01), bytes in consecutive cycles → ctrl_b = FF, cmd_valid pulse.
- Frame AA 01 10 12 → err_pulse, err_code = 1, err_cnt = 1, ctrl_a unchanged. Then AA 03 00 03 → err_code = 2, err_cnt = 2.
- With BT_CMD_TIMEOUT_EN and TIMEOUT_CYC = 100:
  - Send AA 01, then idle → err_code = 3 and busy = 0 one cycle after expiry.
  - Repeat with the ARG byte arriving exactly in the expiry cycle → no error; frame proceeds.
- Send 00 13 AA 02 33 35; assert reset during the 33 byte then release and resend the full frame → leading junk is ignored, all outputs are 0 after reset, and the resent frame gives ctrl_b = 33.
- 300 bad-checksum frames → err_cnt saturates at 255.
